// File: rtl/inst_mem_loader.sv
// inst_mem_loader
//
// Instruction memory with a byte-stream download port. The core fetches
// one word per cycle through a synchronous read port. A loader state
// machine takes a little-endian byte stream, packs it into words and
// writes them from word 0 upward. While a download is in progress the
// core is held and fetch returns NOP.
//
// Optional feature: define ICATCH_CSUM_EN to build a running sum of the
// written words on ld_csum. Without it, ld_csum is tied to 0.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   fetch_addr      word address for the fetch port
//   fetch_en        fetch request
//   inst            fetched word, 1-cycle latency (NOP while blocked)
//   inst_valid      inst holds RAM data for last cycle's request
//   cpu_hold        stall request to the core
//   ld_start        single-cycle pulse that starts a download
//   ld_len          number of words to load, clamped to the memory depth
//   ld_byte         stream byte
//   ld_byte_valid   ld_byte is valid
//   ld_byte_ready   loader accepts a byte this cycle
//   ld_busy         download in progress
//   ld_done         single-cycle completion pulse
//   ld_csum         modulo-2^WIDTH sum of the words written by this load
//
// state | meaning
// IDLE  | fetch enabled, waiting for ld_start
// LOAD  | accepting bytes, core held, fetch returns NOP
// DONE  | one-cycle completion pulse, core still held

module inst_mem_loader #(
   parameter int unsigned      AW    = 10,
   parameter int unsigned      WIDTH = 32,
   parameter logic [WIDTH-1:0] NOP   = 32'h0000_0013
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [AW-1:0]    fetch_addr,
   input  logic             fetch_en,
   output logic [WIDTH-1:0] inst,
   output logic             inst_valid,
   output logic             cpu_hold,
   input  logic             ld_start,
   input  logic [AW:0]      ld_len,
   input  logic [7:0]       ld_byte,
   input  logic             ld_byte_valid,
   output logic             ld_byte_ready,
   output logic             ld_busy,
   output logic             ld_done,
   output logic [WIDTH-1:0] ld_csum
);

   localparam int unsigned NB    = WIDTH / 8;
   localparam int unsigned BCW   = (NB > 1) ? $clog2(NB) : 1;
   localparam int unsigned DEPTH = 1 << AW;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   logic [AW-1:0]    wp;
   logic [AW-1:0]    last_wp;
   logic [BCW-1:0]   bc;
   logic [WIDTH-1:0] asm_reg;
   logic [WIDTH-1:0] mem [DEPTH];

   logic             len_zero;
   logic [AW-1:0]    last_nxt;
   logic             word_end;
   logic             wr_en;
   logic [WIDTH-1:0] wdata;

   // Index of the final word. Lengths above the depth saturate to the
   // top word, so the write pointer never wraps.
   always_comb begin
      len_zero = (ld_len == '0);
      if (ld_len[AW]) begin
         last_nxt = '1;
      end else begin
         last_nxt = ld_len[AW-1:0] - AW'(1);
      end
   end

   // The word being completed merges the incoming byte directly, so the
   // RAM write happens in the same cycle as the final byte.
   always_comb begin
      wdata = asm_reg;
      for (int i = 0; i < int'(NB); i++) begin
         if (bc == BCW'(i)) begin
            wdata[8*i +: 8] = ld_byte;
         end
      end
   end

   assign word_end = (bc == BCW'(NB - 1));
   assign wr_en    = !rst && (state == LOAD) && ld_byte_valid && word_end;

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         wp            <= '0;
         last_wp       <= '0;
         bc            <= '0;
         asm_reg       <= '0;
         ld_byte_ready <= 1'b0;
         ld_busy       <= 1'b0;
         cpu_hold      <= 1'b0;
         ld_done       <= 1'b0;
      end else begin
         ld_done <= 1'b0;
         case (state)
            IDLE: begin
               if (ld_start) begin
                  wp       <= '0;
                  bc       <= '0;
                  last_wp  <= last_nxt;
                  cpu_hold <= 1'b1;
                  if (len_zero) begin
                     state   <= DONE;
                     ld_done <= 1'b1;
                  end else begin
                     state         <= LOAD;
                     ld_byte_ready <= 1'b1;
                     ld_busy       <= 1'b1;
                  end
               end
            end
            LOAD: begin
               if (ld_byte_valid) begin
                  asm_reg <= wdata;
                  if (word_end) begin
                     bc <= '0;
                     wp <= wp + AW'(1);
                     if (wp == last_wp) begin
                        state         <= DONE;
                        ld_done       <= 1'b1;
                        ld_byte_ready <= 1'b0;
                        ld_busy       <= 1'b0;
                     end
                  end else begin
                     bc <= bc + BCW'(1);
                  end
               end
            end
            DONE: begin
               state    <= IDLE;
               cpu_hold <= 1'b0;
            end
            default: begin
               state         <= IDLE;
               ld_byte_ready <= 1'b0;
               ld_busy       <= 1'b0;
               cpu_hold      <= 1'b0;
            end
         endcase
      end
   end

   // RAM contents survive reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wp] <= wdata;
      end
   end

   // Fetch port: reads only while idle; any loader activity forces NOP.
   always_ff @(posedge clk) begin
      if (rst) begin
         inst       <= NOP;
         inst_valid <= 1'b0;
      end else if (state != IDLE) begin
         inst       <= NOP;
         inst_valid <= 1'b0;
      end else if (fetch_en) begin
         inst       <= mem[fetch_addr];
         inst_valid <= 1'b1;
      end else begin
         inst_valid <= 1'b0;
      end
   end

`ifdef ICATCH_CSUM_EN
   logic [WIDTH-1:0] csum;

   always_ff @(posedge clk) begin
      if (rst) begin
         csum <= '0;
      end else if (state == IDLE && ld_start) begin
         csum <= '0;
      end else if (wr_en) begin
         csum <= csum + wdata;
      end
   end

   assign ld_csum = csum;
`else
   assign ld_csum = '0;
`endif

endmodule

// File: tb/tb_inst_mem_loader.sv
module tb_inst_mem_loader;

   localparam int          AW    = 10;
   localparam int          WIDTH = 32;
   localparam int          DEPTH = 1 << AW;
   localparam logic [31:0] NOPW  = 32'h0000_0013;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [AW-1:0]     fetch_addr = '0;
   logic              fetch_en = 1'b0;
   logic [WIDTH-1:0]  inst;
   logic              inst_valid;
   logic              cpu_hold;
   logic              ld_start = 1'b0;
   logic [AW:0]       ld_len = '0;
   logic [7:0]        ld_byte = '0;
   logic              ld_byte_valid = 1'b0;
   logic              ld_byte_ready;
   logic              ld_busy;
   logic              ld_done;
   logic [WIDTH-1:0]  ld_csum;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: memory image and checksum of the current load.
   logic [31:0] mm [DEPTH];
   logic [31:0] model_csum = '0;

   typedef struct {
      logic          en;
      logic [AW-1:0] addr;
      logic [31:0]   exp_inst;
      logic          exp_valid;
   } fvec_t;

   fvec_t fv [7];

   inst_mem_loader #(.AW(AW), .WIDTH(WIDTH), .NOP(NOPW)) dut (
      .clk           (clk),
      .rst           (rst),
      .fetch_addr    (fetch_addr),
      .fetch_en      (fetch_en),
      .inst          (inst),
      .inst_valid    (inst_valid),
      .cpu_hold      (cpu_hold),
      .ld_start      (ld_start),
      .ld_len        (ld_len),
      .ld_byte       (ld_byte),
      .ld_byte_valid (ld_byte_valid),
      .ld_byte_ready (ld_byte_ready),
      .ld_busy       (ld_busy),
      .ld_done       (ld_done),
      .ld_csum       (ld_csum)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic chk1(input string nm, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: actual=%b required=%b", nm, act, exp);
      end
   endtask

   task automatic chk_csum(input string nm);
`ifdef ICATCH_CSUM_EN
      chk(nm, ld_csum, model_csum);
`else
      chk(nm, ld_csum, 32'h0);
`endif
   endtask

   task automatic fetch_chk(input string nm, input logic [AW-1:0] a, input logic [31:0] exp);
      fetch_en   = 1'b1;
      fetch_addr = a;
      tick();
      fetch_en = 1'b0;
      chk({nm, "_inst"}, inst, exp);
      chk1({nm, "_valid"}, inst_valid, 1'b1);
   endtask

   // Starts a load of len words and streams bytes. mode 0: back-to-back,
   // 1: valid toggling, 2: random gaps. Streaming stops after stop_after
   // accepted bytes (a partial load leaves the loader in mid-word).
   task automatic run_load(input string nm, input int len, input logic [7:0] bytes[$],
                           input int mode, input int stop_after);
      int   nbytes;
      int   idx;
      int   cyc;
      int   bad;
      int   budget;
      logic acc;
      logic last;
      logic [31:0] w;
      nbytes = (stop_after < bytes.size()) ? stop_after : bytes.size();
      fetch_en = 1'b0;
      ld_len   = (AW+1)'(len);
      ld_start = 1'b1;
      tick();
      ld_start   = 1'b0;
      model_csum = '0;
      chk1({nm, "_busy_rise"}, ld_busy, 1'b1);
      chk1({nm, "_hold_rise"}, cpu_hold, 1'b1);
      chk1({nm, "_ready_rise"}, ld_byte_ready, 1'b1);
      idx    = 0;
      cyc    = 0;
      bad    = 0;
      budget = 4 * nbytes + 20;
      while (idx < nbytes && cyc < budget) begin
         case (mode)
            0:       acc = 1'b1;
            1:       acc = (cyc % 2 == 0);
            default: acc = ($urandom_range(0, 2) != 0);
         endcase
         ld_byte_valid = acc;
         ld_byte       = bytes[idx];
         fetch_en      = 1'($urandom_range(0, 1));
         fetch_addr    = AW'($urandom);
         tick();
         cyc++;
         if (acc) idx++;
         last = acc && (idx == bytes.size());
         if (ld_done !== last) bad++;
         if (ld_byte_ready !== !last) bad++;
         if (ld_busy !== !last) bad++;
         if (cpu_hold !== 1'b1) bad++;
         if (inst_valid !== 1'b0 || inst !== NOPW) bad++;
      end
      ld_byte_valid = 1'b0;
      fetch_en      = 1'b0;
      chk({nm, "_stream"}, 32'(bad), 32'h0);
      chk({nm, "_bytes_taken"}, 32'(idx), 32'(nbytes));
      for (int k = 0; k < idx / 4; k++) begin
         w = {bytes[4*k+3], bytes[4*k+2], bytes[4*k+1], bytes[4*k]};
         mm[k] = w;
         model_csum = model_csum + w;
      end
      if (idx == bytes.size()) begin
         chk_csum({nm, "_csum"});
         tick();
         chk1({nm, "_done_fall"}, ld_done, 1'b0);
         chk1({nm, "_hold_fall"}, cpu_hold, 1'b0);
         chk_csum({nm, "_csum_stable"});
      end
   endtask

   initial begin
      logic [7:0] q[$];
      int         len;

      fv[0] = '{1'b1, AW'(1), 32'h0020_0113, 1'b1};
      fv[1] = '{1'b1, AW'(0), 32'h0010_0093, 1'b1};
      fv[2] = '{1'b0, AW'(1), 32'h0010_0093, 1'b0};
      fv[3] = '{1'b1, AW'(1), 32'h0020_0113, 1'b1};
      fv[4] = '{1'b0, AW'(0), 32'h0020_0113, 1'b0};
      fv[5] = '{1'b0, AW'(0), 32'h0020_0113, 1'b0};
      fv[6] = '{1'b1, AW'(0), 32'h0010_0093, 1'b1};

      // Reset
      rst = 1'b1;
      tick();
      tick();
      chk("rst_inst", inst, NOPW);
      chk1("rst_valid", inst_valid, 1'b0);
      chk1("rst_hold", cpu_hold, 1'b0);
      chk1("rst_ready", ld_byte_ready, 1'b0);
      chk1("rst_busy", ld_busy, 1'b0);
      chk1("rst_done", ld_done, 1'b0);
      chk("rst_csum", ld_csum, 32'h0);
      rst = 1'b0;
      tick();

      // Basic load, then fetch table
      q = '{8'h93, 8'h00, 8'h10, 8'h00, 8'h13, 8'h01, 8'h20, 8'h00};
      run_load("basic", 2, q, 0, 1 << 30);
`ifdef ICATCH_CSUM_EN
      chk("basic_csum_const", ld_csum, 32'h0030_01A6);
`endif
      for (int i = 0; i < 7; i++) begin
         fetch_en   = fv[i].en;
         fetch_addr = fv[i].addr;
         tick();
         chk($sformatf("fvec%0d_inst", i), inst, fv[i].exp_inst);
         chk1($sformatf("fvec%0d_valid", i), inst_valid, fv[i].exp_valid);
      end
      fetch_en = 1'b0;

      // Stalled stream: overwrite with different data first so the
      // repeated load has something to restore.
      q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
      run_load("pre", 2, q, 0, 1 << 30);
      fetch_chk("pre_w1", AW'(1), 32'h8877_6655);
      q = '{8'h93, 8'h00, 8'h10, 8'h00, 8'h13, 8'h01, 8'h20, 8'h00};
      run_load("stall", 2, q, 1, 1 << 30);
      fetch_chk("stall_w0", AW'(0), 32'h0010_0093);
      fetch_chk("stall_w1", AW'(1), 32'h0020_0113);

      // Zero-length load
      ld_len   = '0;
      ld_start = 1'b1;
      tick();
      ld_start   = 1'b0;
      model_csum = '0;
      chk1("zero_done", ld_done, 1'b1);
      chk1("zero_ready", ld_byte_ready, 1'b0);
      chk1("zero_busy", ld_busy, 1'b0);
      chk1("zero_hold", cpu_hold, 1'b1);
      chk_csum("zero_csum");
      tick();
      chk1("zero_done_fall", ld_done, 1'b0);
      chk1("zero_ready2", ld_byte_ready, 1'b0);
      chk1("zero_hold_fall", cpu_hold, 1'b0);
      fetch_chk("zero_w0", AW'(0), 32'h0010_0093);

      // Reset after 6 of 8 bytes
      q = '{8'hD4, 8'hC3, 8'hB2, 8'hA1, 8'h44, 8'h33, 8'h22, 8'h11};
      run_load("rml", 2, q, 0, 6);
      rst = 1'b1;
      tick();
      chk1("rml_busy", ld_busy, 1'b0);
      chk1("rml_done", ld_done, 1'b0);
      chk1("rml_ready", ld_byte_ready, 1'b0);
      chk1("rml_hold", cpu_hold, 1'b0);
      rst        = 1'b0;
      model_csum = '0;
      chk_csum("rml_csum");
      tick();
      chk1("rml_done2", ld_done, 1'b0);
      fetch_chk("rml_w0", AW'(0), 32'hA1B2_C3D4);
      fetch_chk("rml_w1", AW'(1), 32'h0020_0113);
      q = '{8'h0D, 8'hF0, 8'hFE, 8'hCA};
      run_load("rml_new", 1, q, 0, 1 << 30);
      fetch_chk("rml_new_w0", AW'(0), 32'hCAFE_F00D);

      // Randomized loads against the model
      for (int it = 0; it < 6; it++) begin
         len = $urandom_range(1, 6);
         q.delete();
         for (int b = 0; b < 4 * len; b++) q.push_back(8'($urandom));
         run_load($sformatf("rnd%0d", it), len, q, 2, 1 << 30);
         for (int f = 0; f < 3; f++) begin
            int a;
            a = $urandom_range(0, len - 1);
            fetch_chk($sformatf("rnd%0d_f%0d", it, f), AW'(a), mm[a]);
         end
      end

      // Clamped full-depth load
      q.delete();
      for (int b = 0; b < 4 * DEPTH; b++) q.push_back(8'hFF);
      run_load("clamp", DEPTH + 5, q, 0, 1 << 30);
`ifdef ICATCH_CSUM_EN
      chk("clamp_csum_const", ld_csum, 32'hFFFF_FC00);
`endif
      fetch_chk("clamp_top", AW'(DEPTH - 1), 32'hFFFF_FFFF);
      fetch_chk("clamp_w0", AW'(0), 32'hFFFF_FFFF);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
